fm_prenormalize: RTL and testbench
==================================

FM_PRENORMALIZE -- requirements
Module: fm_prenormalize

Interface
REQ-001 Parameter EXPWIDTH, default 8, IEEE exponent field width.
REQ-002 Parameter SIGWIDTH, default 23, IEEE fraction field width.
REQ-003 Parameter BIAS, default 127, exponent bias; used only to document exponent encoding, no arithmetic on it.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand offered.
REQ-007 in_data  input  EXPWIDTH+SIGWIDTH+1  IEEE operand {sign, exponent, fraction}.
REQ-008 in_ready  output  1  block accepts operand this cycle.
REQ-009 out_valid  output  1  unpacked result available.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 out_sign  output  1  operand sign.
REQ-012 out_exp  output  EXPWIDTH+2  biased exponent, two's complement, may go negative for denormals.
REQ-013 out_mant  output  SIGWIDTH+1  significand with explicit leading bit at MSB.
REQ-014 out_zero, out_inf, out_nan, out_denorm  output  1 each  operand class flags.

Function
REQ-015 FSM states IDLE, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 IDLE: on in_valid, capture sign, exponent, fraction in the same edge; in_valid while not in IDLE is ignored, and the source holds data.
REQ-017 Normal operand (exponent field 1..2^EXPWIDTH-2): out_exp = zero-extended field, out_mant = {1,fraction}; next state DONE (out_valid one cycle after acceptance).
REQ-018 Zero (field 0, fraction 0): out_exp 0, out_mant 0, out_zero 1; next state DONE.
REQ-019 Inf (field all-ones, fraction 0): out_exp = all-ones field, out_mant = {1,0...}, out_inf 1; next state DONE.
REQ-020 NaN (field all-ones, fraction nonzero): out_exp = all-ones field, out_mant = {1,fraction}, out_nan 1; next state DONE.
REQ-021 Denormal (field 0, fraction nonzero): load mant = {0,fraction}, exp = 1, out_denorm 1; next state SHIFT.
REQ-022 SHIFT: each cycle mant <<= 1 and exp -= 1 (two's complement, EXPWIDTH+2 bits); transition to DONE on the edge where the shifted mant MSB becomes 1.
REQ-023 Denormal latency: k+1 cycles from acceptance to out_valid, k = leading zeros of {0,fraction} (1..SIGWIDTH); final exp = 1-k; maximum 24 cycles at defaults.
REQ-024 DONE: all out_* held stable until out_valid && out_ready; that edge returns to IDLE.
REQ-025 No overlap: next operand is accepted no earlier than the cycle after the handshake; peak throughput is 1 operand per 2 cycles.
REQ-026 Exactly one class flag is 1 per result, or none for a normal operand; flags are cleared at each acceptance.

Reset
REQ-027 rst_n low asynchronously forces state IDLE, and all out_* registers to 0; in_ready is 1 and out_valid 0 while in reset.
REQ-028 Reset asserted during SHIFT or DONE discards the operand; no out_valid follows its release.

Verification
REQ-029 in_data 0x3F800000 -> out_valid next cycle, sign 0, exp 10'h07F, mant 0x800000, all flags 0.
REQ-030 in_data 0x00000001 -> out_valid 24 cycles after acceptance, exp 10'h3EA (-22), mant 0x800000, out_denorm 1; in_data 0x00400000 -> 2 cycles, exp 0, mant 0x800000.
REQ-031 in_data 0x80000000 -> sign 1, exp 0, mant 0, out_zero 1; 0x7F800000 -> exp 10'h0FF, mant 0x800000, out_inf 1; 0x7FC00000 -> mant 0xC00000, out_nan 1.
REQ-032 out_ready held low 5 cycles in DONE -> outputs unchanged, in_ready 0, and in_valid pulses ignored; out_ready high -> IDLE next cycle.
REQ-033 rst_n pulsed low mid-SHIFT on 0x00000001 -> out_valid 0 and in_ready 1 immediately; the next operand 0x3F800000 completes normally.
REQ-034 Back-to-back in_valid with out_ready tied high -> acceptances exactly 2 cycles apart for normal operands.

Source files
------------

// File: rtl/fm_prenormalize.sv
// fm_prenormalize: unpacks an IEEE operand into sign/exponent/explicit-significand, normalising denormals by shifting.
module fm_prenormalize #(
   parameter int EXPWIDTH = 8,
   parameter int SIGWIDTH = 23,
   parameter int BIAS     = 127
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   input  logic [EXPWIDTH+SIGWIDTH:0]   in_data,
   output logic                         in_ready,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_sign,
   output logic [EXPWIDTH+1:0]          out_exp,
   output logic [SIGWIDTH:0]            out_mant,
   output logic                         out_zero,
   output logic                         out_inf,
   output logic                         out_nan,
   output logic                         out_denorm
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam logic [EXPWIDTH+1:0] EXP_ONE = {{(EXPWIDTH+1){1'b0}}, 1'b1};
   state_t state, state_nx;
   logic [EXPWIDTH-1:0] exp_f;
   logic [SIGWIDTH-1:0] frac;
   logic exp_zero, exp_ones, frac_nz, accept, unused_bias;
   // BIAS only documents the exponent encoding; the exponent stays biased throughout
   assign unused_bias = ^BIAS;
   assign exp_f    = in_data[EXPWIDTH+SIGWIDTH-1:SIGWIDTH];
   assign frac     = in_data[SIGWIDTH-1:0];
   assign exp_zero = exp_f == '0;
   assign exp_ones = &exp_f;
   assign frac_nz  = |frac;
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign accept    = in_ready && in_valid;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      if (accept) state_nx = (exp_zero && frac_nz) ? SHIFT : DONE;
      else if (state == SHIFT && out_mant[SIGWIDTH-1]) state_nx = DONE;
      else if (state == DONE && out_ready) state_nx = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_sign   <= 1'b0;
         out_exp    <= '0;
         out_mant   <= '0;
         out_zero   <= 1'b0;
         out_inf    <= 1'b0;
         out_nan    <= 1'b0;
         out_denorm <= 1'b0;
      end else if (accept) begin
         out_sign   <= in_data[EXPWIDTH+SIGWIDTH];
         out_exp    <= exp_zero ? {{(EXPWIDTH+1){1'b0}}, frac_nz} : {2'b00, exp_f};
         out_mant   <= {!exp_zero, frac};
         out_zero   <= exp_zero && !frac_nz;
         out_inf    <= exp_ones && !frac_nz;
         out_nan    <= exp_ones && frac_nz;
         out_denorm <= exp_zero && frac_nz;
      end else if (state == SHIFT) begin
         out_mant <= out_mant << 1;
         out_exp  <= out_exp - EXP_ONE;
      end
endmodule

// File: tb/tb_fm_prenormalize.sv
// tb_fm_prenormalize: directed single-precision vectors with hand-computed unpack results and latencies.
module tb_fm_prenormalize;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready, out_valid;
   logic        out_ready = 1'b0;
   logic        out_sign, out_zero, out_inf, out_nan, out_denorm;
   logic [9:0]  out_exp;
   logic [23:0] out_mant;
   int checks = 0;
   int errors = 0;

   fm_prenormalize dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp),
      .out_mant(out_mant), .out_zero(out_zero), .out_inf(out_inf), .out_nan(out_nan),
      .out_denorm(out_denorm)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run(input string tag, input logic [31:0] d, input int lat_e, input logic s_e,
                      input logic [9:0] e_e, input logic [23:0] m_e, input logic [3:0] f_e);
      int lat;
      @(negedge clk);
      check({tag, " in_ready"}, 32'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      check({tag, " latency"}, lat, lat_e);
      check({tag, " sign"}, 32'(out_sign), 32'(s_e));
      check({tag, " exp"}, 32'(out_exp), 32'(e_e));
      check({tag, " mant"}, 32'(out_mant), 32'(m_e));
      check({tag, " flags"}, 32'({out_zero, out_inf, out_nan, out_denorm}), 32'(f_e));
   endtask

   task automatic pop(input string tag);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({tag, " pop in_ready"}, 32'(in_ready), 1);
      check({tag, " pop out_valid"}, 32'(out_valid), 0);
   endtask

   initial begin
      int seen;
      int acc [$];
      #12;
      check("rst in_ready", 32'(in_ready), 1);
      check("rst out_valid", 32'(out_valid), 0);
      check("rst exp", 32'(out_exp), 0);
      check("rst mant", 32'(out_mant), 0);
      check("rst flags", 32'({out_sign, out_zero, out_inf, out_nan, out_denorm}), 0);
      @(negedge clk) rst_n = 1'b1;

      run("one", 32'h3F800000, 1, 1'b0, 10'h07F, 24'h800000, 4'b0000); pop("one");
      run("dmin", 32'h00000001, 24, 1'b0, 10'h3EA, 24'h800000, 4'b0001); pop("dmin");
      run("dhalf", 32'h00400000, 2, 1'b0, 10'h000, 24'h800000, 4'b0001); pop("dhalf");
      run("nzero", 32'h80000000, 1, 1'b1, 10'h000, 24'h000000, 4'b1000); pop("nzero");
      run("inf", 32'h7F800000, 1, 1'b0, 10'h0FF, 24'h800000, 4'b0100); pop("inf");
      run("nan", 32'h7FC00000, 1, 1'b0, 10'h0FF, 24'hC00000, 4'b0010); pop("nan");
      run("dmid", 32'h80012345, 8, 1'b1, 10'h3FA, 24'h91A280, 4'b0001); pop("dmid");

      run("pi", 32'h40490FDB, 1, 1'b0, 10'h080, 24'hC90FDB, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold out_valid", 32'(out_valid), 1);
         check("hold in_ready", 32'(in_ready), 0);
         check("hold mant", 32'(out_mant), 32'hC90FDB);
         check("hold exp", 32'(out_exp), 32'h080);
         in_valid = 1'b1;
         in_data  = 32'h3F800000;
      end
      pop("pi");
      @(negedge clk);
      check("pi no stray out_valid", 32'(out_valid), 0);

      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h00000001;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst out_valid", 32'(out_valid), 0);
      check("midrst in_ready", 32'(in_ready), 1);
      check("midrst mant", 32'(out_mant), 0);
      @(negedge clk) rst_n = 1'b1;
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("midrst no out_valid", seen, 0);
      run("after rst", 32'h3F800000, 1, 1'b0, 10'h07F, 24'h800000, 4'b0000); pop("after rst");

      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h3F800000;
      for (int c = 0; c < 10; c++) begin
         if (in_ready) acc.push_back(c);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b count", acc.size(), 5);
      for (int i = 1; i < acc.size(); i++) check("b2b gap", acc[i] - acc[i-1], 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
